ysyx_25020037_lsu_axi: RTL and testbench

- Parametrised AXI4 load/store unit between EXU and WBU.
- Replaces the fixed 32-bit LSU.
- Adds configurable data width, sign/zero extension of loads and misalignment trapping without a bus access.
- Adds independent AW/W channel completion, a registered MMIO difftest-skip pulse, and a fault-cause code for the WBU trap logic.

---
 rtl/ysyx_25020037_lsu_pkg.sv | 35 +++
 rtl/ysyx_25020037_lsu_align.sv | 61 ++++++
 rtl/ysyx_25020037_lsu_axi.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ysyx_25020037_lsu_axi.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020037_lsu_pkg.sv
// Shared types and constants for the AXI4 load/store unit.
// Imported by the alignment helper and the LSU top.
package ysyx_25020037_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_RESP
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR   = 2'd2;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;

  function automatic logic addr_in(
    input logic [31:0] a,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/ysyx_25020037_lsu_align.sv
// Byte-lane alignment: load extraction/extension, store shift,
// write strobes and misalignment detection.
module ysyx_25020037_lsu_align
  import ysyx_25020037_lsu_pkg::*;
#(
  parameter int DW = 32,
  localparam int SW = DW / 8,
  localparam int OW = $clog2(SW)
) (
  input  logic [1:0]    size_i,
  input  logic [OW-1:0] off_i,
  input  logic          unsigned_i,
  input  logic [DW-1:0] rdata_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] ldata_o,
  output logic [DW-1:0] sdata_o,
  output logic [SW-1:0] wstrb_o,
  output logic          misalign_o
);

  logic [DW-1:0] sh;
  logic [DW-1:0] mask;
  logic [SW-1:0] base;
  logic          sgn;

  always_comb begin
    sh         = rdata_i >> {off_i, 3'b000};
    mask       = '1;
    sgn        = sh[DW-1];
    base       = '1;
    misalign_o = 1'b0;
    unique case (size_i)
      SZ_B: begin
        mask = DW'(8'hFF);
        sgn  = sh[7];
        base = SW'(1);
      end
      SZ_H: begin
        mask       = DW'(16'hFFFF);
        sgn        = sh[15];
        base       = SW'(2'b11);
        misalign_o = off_i[0];
      end
      SZ_W: begin
        mask       = DW'(32'hFFFF_FFFF);
        sgn        = sh[31];
        base       = SW'(4'hF);
        misalign_o = |off_i[1:0];
      end
      default: begin
        // dword is illegal on a 32-bit bus
        misalign_o = (DW == 32) | (|off_i);
      end
    endcase
    ldata_o = (sh & mask)
            | ({DW{sgn & ~unsigned_i}} & ~mask);
    sdata_o = wdata_i << {off_i, 3'b000};
    wstrb_o = base << off_i;
  end

endmodule

// File: rtl/ysyx_25020037_lsu_axi.sv
// AXI4 single-beat load/store unit between EXU and WBU.
// Misaligned requests trap without touching the bus.
module ysyx_25020037_lsu_axi
  import ysyx_25020037_lsu_pkg::*;
#(
  parameter int          DW         = 32,
  parameter logic [3:0]  AXI_ID_VAL = 4'h0,
  parameter logic [31:0] SDRAM_BASE = 32'hA000_0000,
  parameter logic [31:0] SDRAM_END  = 32'hBFFF_FFFF,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter logic [31:0] MMIO_END   = 32'h1000_0FFF,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_END  = 32'h0200_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic            req_load,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_addr,
  output logic [DW-1:0]   out_rdata,
  output logic            out_fault,
  output logic [1:0]      out_cause,
  output logic            skip_ref,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     awaddr,
  output logic [3:0]      awid,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            wvalid,
  input  logic            wready,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wlast,
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp,
  input  logic [3:0]      bid,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [3:0]      arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  input  logic            rvalid,
  output logic            rready,
  input  logic [DW-1:0]   rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic [3:0]      rid
);

  localparam int SW = DW / 8;
  localparam int OW = $clog2(SW);
  localparam logic [2:0] SZ_BUS = 3'($clog2(SW));

  lsu_state_e    state_q, state_d;
  logic [31:0]   addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [2:0]    axsize_q, axsize_d;
  logic [1:0]    burst_q, burst_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          skip_q, skip_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic [1:0]    cause_q, cause_d;

  logic          idle, mem, bad, hit, sdram;
  logic          aw_done, w_done;
  logic [1:0]    a_size;
  logic [OW-1:0] a_off;
  logic          a_uns;
  logic [DW-1:0] ldata, sdata;
  logic [SW-1:0] sstrb;
  logic          misalign;
  logic          unused_ok;

  assign unused_ok = ^{rid, bid, rlast};

  assign idle   = (state_q == S_IDLE);
  assign mem    = req_load | req_store;
  assign bad    = mem & misalign;
  assign sdram  = addr_in(req_addr, SDRAM_BASE, SDRAM_END);
  assign hit    = addr_in(addr_q, MMIO_BASE, MMIO_END)
                | addr_in(addr_q, CLINT_BASE, CLINT_END);
  assign aw_done = ~awvalid_q | awready;
  assign w_done  = ~wvalid_q | wready;

  // Request fields feed the aligner at accept, latched ones afterwards
  assign a_size = idle ? req_size : size_q;
  assign a_off  = idle ? req_addr[OW-1:0] : addr_q[OW-1:0];
  assign a_uns  = idle ? req_unsigned : uns_q;

  ysyx_25020037_lsu_align #(.DW(DW)) u_align (
    .size_i     (a_size),
    .off_i      (a_off),
    .unsigned_i (a_uns),
    .rdata_i    (rdata),
    .wdata_i    (req_wdata),
    .ldata_o    (ldata),
    .sdata_o    (sdata),
    .wstrb_o    (sstrb),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      axsize_q  <= SZ_BUS;
      burst_q   <= AXI_BURST_FIXED;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      skip_q    <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      if (idle && in_valid) begin
        addr_q <= req_addr;
        size_q <= req_size;
        uns_q  <= req_unsigned;
      end
      axsize_q  <= axsize_d;
      burst_q   <= burst_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      skip_q    <= skip_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!mem || bad) state_d = S_RESP;
          else if (req_load) state_d = S_AR;
          else state_d = S_WR;
        end
      end
      S_AR:   if (arready) state_d = S_R;
      S_R:    if (rvalid) state_d = S_RESP;
      S_WR:   if (aw_done && w_done) state_d = S_B;
      S_B:    if (bvalid) state_d = S_RESP;
      S_RESP: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    axsize_d  = axsize_q;
    burst_d   = burst_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    skip_d    = 1'b0;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    cause_d   = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          axsize_d  = {1'b0, req_size};
          burst_d   = sdram ? AXI_BURST_INCR : AXI_BURST_FIXED;
          rdata_d   = mem ? '0 : DW'(req_addr);
          fault_d   = bad;
          cause_d   = bad ? CAUSE_MISALIGN : CAUSE_NONE;
          wdata_d   = sdata;
          wstrb_d   = sstrb;
          arvalid_d = mem & ~bad & req_load;
          awvalid_d = mem & ~bad & ~req_load;
          wvalid_d  = mem & ~bad & ~req_load;
        end
      end
      S_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          skip_d    = hit;
        end
      end
      S_R: begin
        if (rvalid) begin
          rready_d = 1'b0;
          rdata_d  = ldata;
          fault_d  = |rresp;
          cause_d  = (|rresp) ? CAUSE_BUSERR : CAUSE_NONE;
        end
      end
      S_WR: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          skip_d   = hit;
        end
      end
      S_B: begin
        if (bvalid) begin
          bready_d = 1'b0;
          fault_d  = |bresp;
          cause_d  = (|bresp) ? CAUSE_BUSERR : CAUSE_NONE;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = idle;
  assign out_valid = (state_q == S_RESP);
  assign out_addr  = addr_q;
  assign out_rdata = rdata_q;
  assign out_fault = fault_q;
  assign out_cause = cause_q;
  assign skip_ref  = skip_q;

  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awid    = AXI_ID_VAL;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = axsize_q;
  assign awburst = burst_q;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign bready  = bready_q;
  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arid    = AXI_ID_VAL;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = axsize_q;
  assign arburst = burst_q;
  assign rready  = rready_q;

endmodule

// File: tb/tb_ysyx_25020037_lsu_axi.sv
// Directed bench for the AXI load/store unit (DW=32) with a
// small AXI slave whose AW/W ready delays are configurable.
module tb_ysyx_25020037_lsu_axi;

  localparam logic [1:0] BF = 2'b00;
  localparam logic [1:0] BI = 2'b01;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_load, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_rdata;
  logic        out_fault;
  logic [1:0]  out_cause;
  logic        skip_ref;
  logic        awvalid, awready, wvalid, wready, wlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, wstrb, bid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;

  ysyx_25020037_lsu_axi dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_load(req_load), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_rdata(out_rdata),
    .out_fault(out_fault), .out_cause(out_cause),
    .skip_ref(skip_ref),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // slave configuration
  logic [31:0] cfg_rd;
  logic [1:0]  cfg_resp;
  int          cfg_awd, cfg_wdl;
  logic        r_hold;

  initial begin
    int aw_cnt, w_cnt;
    aw_cnt = 0; w_cnt = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    bid = 0; rid = 0; rlast = 1;
    cfg_rd = 0; cfg_resp = 0; cfg_awd = 0; cfg_wdl = 0;
    r_hold = 0;
    forever begin
      @(negedge clk);
      arready = arvalid;
      rvalid  = rready & ~r_hold;
      rdata   = cfg_rd;
      rresp   = cfg_resp;
      if (awvalid) begin
        awready = (aw_cnt >= cfg_awd); aw_cnt++;
      end else begin
        awready = 0; aw_cnt = 0;
      end
      if (wvalid) begin
        wready = (w_cnt >= cfg_wdl); w_cnt++;
      end else begin
        wready = 0; w_cnt = 0;
      end
      bvalid = bready;
      bresp  = cfg_resp;
    end
  end

  // handshake monitors
  int ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  int vld_cnt = 0, skip_cnt = 0, split_cnt = 0, out_hs = 0;
  logic [1:0]  c_arburst, c_awburst;
  logic [2:0]  c_arsize, c_awsize;
  logic [31:0] c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_wlast;

  always @(posedge clk) begin
    if (arvalid && arready) begin
      ar_hs <= ar_hs + 1;
      c_arburst <= arburst; c_arsize <= arsize;
    end
    if (awvalid && awready) begin
      aw_hs <= aw_hs + 1;
      c_awburst <= awburst; c_awsize <= awsize;
    end
    if (wvalid && wready) begin
      w_hs <= w_hs + 1;
      c_wdata <= wdata; c_wstrb <= wstrb; c_wlast <= wlast;
    end
    if (bvalid && bready) b_hs <= b_hs + 1;
    if (arvalid || awvalid || wvalid) vld_cnt <= vld_cnt + 1;
    if (skip_ref) skip_cnt <= skip_cnt + 1;
    if (awvalid != wvalid) split_cnt <= split_cnt + 1;
    if (out_valid && out_ready) out_hs <= out_hs + 1;
  end

  typedef struct {
    logic ld; logic st; logic [1:0] sz; logic uns;
    logic [31:0] addr; logic [31:0] wd; logic [31:0] rd;
    logic [1:0] resp; int awd; int wdl;
    logic [31:0] erd; logic ef; logic [1:0] ec; int elat;
    logic [1:0] eb; logic es; logic [31:0] ewd; logic [3:0] ews;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic ld, input logic st, input logic [1:0] sz,
    input logic uns, input logic [31:0] addr,
    input logic [31:0] wd, input logic [31:0] rd,
    input logic [1:0] resp, input int awd, input int wdl,
    input logic [31:0] erd, input logic ef,
    input logic [1:0] ec, input int elat, input logic [1:0] eb,
    input logic es, input logic [31:0] ewd, input logic [3:0] ews
  );
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.uns = uns;
    v.addr = addr; v.wd = wd; v.rd = rd; v.resp = resp;
    v.awd = awd; v.wdl = wdl; v.erd = erd; v.ef = ef;
    v.ec = ec; v.elat = elat; v.eb = eb; v.es = es;
    v.ewd = ewd; v.ews = ews;
    return v;
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    int lat, a0, aw0, w0, b0, vs0, sk0, sp0, oh0;
    logic ar_e, wr_e;
    v = vt[i];
    ar_e = v.ld & (v.ec != 2'd1);
    wr_e = v.st & ~v.ld & (v.ec != 2'd1);
    @(negedge clk);
    chk($sformatf("v%0d in_ready", i), in_ready, 1);
    cfg_rd = v.rd; cfg_resp = v.resp;
    cfg_awd = v.awd; cfg_wdl = v.wdl;
    a0 = ar_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    vs0 = vld_cnt; sk0 = skip_cnt; sp0 = split_cnt; oh0 = out_hs;
    in_valid = 1; req_load = v.ld; req_store = v.st;
    req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", i), lat, v.elat);
    chk($sformatf("v%0d rdata", i), out_rdata, v.erd);
    chk($sformatf("v%0d fault", i), out_fault, v.ef);
    chk($sformatf("v%0d cause", i), out_cause, v.ec);
    chk($sformatf("v%0d out_addr", i), out_addr, v.addr);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d out_hs", i), out_hs - oh0, 1);
    chk($sformatf("v%0d ar_hs", i), ar_hs - a0, ar_e);
    chk($sformatf("v%0d aw_hs", i), aw_hs - aw0, wr_e);
    chk($sformatf("v%0d w_hs", i), w_hs - w0, wr_e);
    chk($sformatf("v%0d b_hs", i), b_hs - b0, wr_e);
    chk($sformatf("v%0d bus_used", i), vld_cnt != vs0, ar_e | wr_e);
    chk($sformatf("v%0d skip", i), skip_cnt - sk0, v.es);
    if (ar_e) begin
      chk($sformatf("v%0d arburst", i), c_arburst, v.eb);
      chk($sformatf("v%0d arsize", i), c_arsize, {1'b0, v.sz});
    end
    if (wr_e) begin
      chk($sformatf("v%0d awburst", i), c_awburst, v.eb);
      chk($sformatf("v%0d awsize", i), c_awsize, {1'b0, v.sz});
      chk($sformatf("v%0d wdata", i), c_wdata, v.ewd);
      chk($sformatf("v%0d wstrb", i), c_wstrb, v.ews);
      chk($sformatf("v%0d wlast", i), c_wlast, 1);
      chk($sformatf("v%0d split", i), split_cnt != sp0,
          v.awd != v.wdl);
    end
  endtask

  initial begin
    int n, oh0;
    rst = 1; in_valid = 0; out_ready = 1;
    req_addr = 0; req_wdata = 0; req_load = 0; req_store = 0;
    req_size = 0; req_unsigned = 0;

    // ld st sz uns addr wd rd resp awd wdl | erd ef ec lat burst skip ewd ews
    vt.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'hA000_0003, 32'h0,
      32'h8012_3456, 2'd0, 0, 0, 32'hFFFF_FF80, 1'b0, 2'd0, 3,
      BI, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'hA000_0003, 32'h0,
      32'h8012_3456, 2'd0, 0, 0, 32'h0000_0080, 1'b0, 2'd0, 3,
      BI, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0,
      32'hBEEF_1234, 2'd0, 0, 0, 32'hFFFF_BEEF, 1'b0, 2'd0, 3,
      BF, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0,
      32'h1234_5678, 2'd0, 0, 0, 32'h1234_5678, 1'b0, 2'd0, 3,
      BF, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h8000_0000, 32'h0,
      32'h0000_F00D, 2'd0, 0, 0, 32'h0000_F00D, 1'b0, 2'd0, 3,
      BF, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h8000_0002,
      32'h0000_1234, 32'h0, 2'd0, 0, 0, 32'h0, 1'b0, 2'd0, 3,
      BF, 1'b0, 32'h1234_0000, 4'b1100));
    vt.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'hA000_0001,
      32'h0000_00AB, 32'h0, 2'd0, 0, 0, 32'h0, 1'b0, 2'd0, 3,
      BI, 1'b0, 32'h0000_AB00, 4'b0010));
    vt.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h8000_0000,
      32'hDEAD_BEEF, 32'h0, 2'd0, 0, 2, 32'h0, 1'b0, 2'd0, 5,
      BF, 1'b0, 32'hDEAD_BEEF, 4'hF));
    vt.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h8000_0010,
      32'hCAFE_F00D, 32'h0, 2'd0, 2, 0, 32'h0, 1'b0, 2'd0, 5,
      BF, 1'b0, 32'hCAFE_F00D, 4'hF));
    vt.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0,
      32'h1111_1111, 2'd0, 0, 0, 32'h0, 1'b1, 2'd1, 1,
      BF, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0,
      32'h1111_1111, 2'd0, 0, 0, 32'h0, 1'b1, 2'd1, 1,
      BF, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h8000_0001,
      32'h0000_1234, 32'h0, 2'd0, 0, 0, 32'h0, 1'b1, 2'd1, 1,
      BF, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234_5679, 32'h0,
      32'h0, 2'd0, 0, 0, 32'h1234_5679, 1'b0, 2'd0, 1,
      BF, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'h0,
      32'hCAFE_BABE, 2'd2, 0, 0, 32'hCAFE_BABE, 1'b1, 2'd2, 3,
      BF, 1'b1, 32'h0, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0200_0010,
      32'h1122_3344, 32'h0, 2'd2, 0, 0, 32'h0, 1'b1, 2'd2, 3,
      BF, 1'b1, 32'h1122_3344, 4'hF));
    vt.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0200_FFFC, 32'h0,
      32'h0000_0001, 2'd0, 0, 0, 32'h0000_0001, 1'b0, 2'd0, 3,
      BF, 1'b1, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0201_0000, 32'h0,
      32'h0000_0002, 2'd0, 0, 0, 32'h0000_0002, 1'b0, 2'd0, 3,
      BF, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'hBFFF_FFFC, 32'h0,
      32'h0000_0003, 2'd0, 0, 0, 32'h0000_0003, 1'b0, 2'd0, 3,
      BI, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'hC000_0000, 32'h0,
      32'h0000_0004, 2'd0, 0, 0, 32'h0000_0004, 1'b0, 2'd0, 3,
      BF, 1'b0, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h1000_0FFF, 32'h0,
      32'h7F00_0000, 2'd0, 0, 0, 32'h0000_007F, 1'b0, 2'd0, 3,
      BF, 1'b1, 32'h0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0,
      32'h0000_8000, 2'd0, 0, 0, 32'hFFFF_FF80, 1'b0, 2'd0, 3,
      BF, 1'b0, 32'h0, 4'h0));

    // reset values while rst is held
    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst arvalid", arvalid, 0);
    chk("rst awvalid", awvalid, 0);
    chk("rst wvalid", wvalid, 0);
    chk("rst rready", rready, 0);
    chk("rst bready", bready, 0);
    chk("rst skip_ref", skip_ref, 0);
    chk("rst awlen", awlen, 0);
    chk("rst arlen", arlen, 0);
    chk("rst wlast", wlast, 1);
    chk("rst arsize", arsize, 3'd2);
    chk("rst awsize", awsize, 3'd2);
    chk("rst arburst", arburst, BF);
    chk("rst awburst", awburst, BF);
    chk("rst araddr", araddr, 0);
    chk("rst wdata", wdata, 0);
    chk("rst wstrb", wstrb, 0);
    chk("rst out_rdata", out_rdata, 0);
    rst = 0;

    foreach (vt[i]) run_vec(i);

    // RESP back-pressure: outputs held while out_ready is low
    @(negedge clk);
    out_ready = 0; cfg_rd = 32'h55AA_55AA; cfg_resp = 0;
    in_valid = 1; req_load = 1; req_store = 0; req_size = 2'd2;
    req_unsigned = 0; req_addr = 32'h8000_0008;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold reach", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold out_valid", out_valid, 1);
      chk("hold in_ready", in_ready, 0);
      chk("hold rdata", out_rdata, 32'h55AA_55AA);
      chk("hold addr", out_addr, 32'h8000_0008);
    end
    out_ready = 1;
    @(negedge clk);
    chk("release out_valid", out_valid, 0);
    chk("release in_ready", in_ready, 1);

    // reset while waiting for read data
    r_hold = 1;
    oh0 = out_hs;
    in_valid = 1; req_load = 1; req_store = 0; req_size = 2'd2;
    req_addr = 32'h8000_0010;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!rready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rstR in R", rready, 1);
    rst = 1;
    @(negedge clk);
    chk("rstR arvalid", arvalid, 0);
    chk("rstR rready", rready, 0);
    chk("rstR awvalid", awvalid, 0);
    chk("rstR wvalid", wvalid, 0);
    chk("rstR bready", bready, 0);
    chk("rstR out_valid", out_valid, 0);
    chk("rstR in_ready", in_ready, 1);
    rst = 0; r_hold = 0;
    @(negedge clk);
    chk("rstR no completion", out_hs - oh0, 0);

    run_vec(0);
    run_vec(7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
